key_tracker: RTL
================

Name: key_tracker

Overview:
- Game-logic block that owns key-collection progress in STAGE1 and produces the 2-bit key_find code consumed by the key/light sprite renderer.
- Compares the player hitbox against the active key's 20x20 box in 320x240 space.
- Requires interact to be held for a fixed number of frames before a pickup.
- Advances key_find 0 -> 1 -> 2 -> 3 (FIND_DOOR) and pulses stage events toward the top-level FSM.

Parameters:
- HOLD_FRAMES, 30, frames interact must stay asserted while overlapping before a pickup.
- PLAYER_W, 16, player hitbox width and height in 320x240 units.
- KEY_SIZE, 20, key box width and height.
- KEY0_X/KEY0_Y, 65/35, origin of key 0.
- KEY1_X/KEY1_Y, 235/35, origin of key 1.
- KEY2_X/KEY2_Y, 235/205, origin of key 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- state  in  4  top-level game state (TITLE=0 … STAGE1=2 … FAIL=8)
- frame_tick  in  1  one-cycle pulse per frame (vsync start)
- player_x  in  9  player hitbox left edge, 0..319
- player_y  in  9  player hitbox top edge, 0..239
- interact  in  1  debounced interact button, level
- key_find  out  2  0/1/2 = key N active, 3 = all keys found (FIND_DOOR)
- key_pickup  out  1  one-cycle pulse on each pickup
- keys_done  out  1  one-cycle pulse when key_find becomes 3
- hold_progress  out  5  frames held so far, saturating at HOLD_FRAMES (progress bar)

Behaviour:
- Reset is synchronous, active-low, and has priority over everything else. Reset values: key_find=0, key_pickup=0, keys_done=0, hold_progress=0, FSM=IDLE, hold counter=0, prev_state=TITLE.
- FSM states and transitions:
  - IDLE: entered whenever state != STAGE1. key_find holds its value so SUCCESS1 still sees 3. On entry to STAGE1 from any other state (prev_state != STAGE1), clear key_find=0, clear the counter, and go to SEARCH.
  - SEARCH: if overlap && interact, go to HOLD with counter=0.
  - HOLD: on each frame_tick with overlap && interact, increment the counter. Drop of either condition returns to SEARCH with counter=0 on the next cycle, independent of frame_tick. When the counter reaches HOLD_FRAMES on a frame_tick:
    - same cycle: key_find+1 and key_pickup=1;
    - if the new key_find is 3, also pulse keys_done and go to DONE;
    - otherwise go to COOLDOWN.
  - COOLDOWN: wait for interact=0, then go to SEARCH. Holding the button never chains pickups.
  - DONE: stay until state leaves STAGE1, then go to IDLE.
- Overlap rule: (player_x < kx+KEY_SIZE) && (player_x+PLAYER_W > kx), and the same test on y. Compute in 10 bits, no wrap. kx/ky are selected by key_find; when key_find=3 there is never overlap.
- Simultaneous events:
  - state leaving STAGE1 in the same cycle as a completing frame_tick: the leave wins, no pickup.
  - interact dropping on the completing tick: no pickup.
- Timing: hold_progress is registered and equals the counter. Pickup latency is 0 cycles after the qualifying frame_tick edge (registered outputs visible the next cycle).
- Pulses are exactly one cycle wide.

Optional Feature:
- KEY_SKIP_EN defined:
  - adds input skip_key (1 bit);
  - a rising edge of skip_key in SEARCH/HOLD/COOLDOWN performs an immediate pickup with the same outputs and transitions as a completed hold.
- Undefined: the port is absent and pickups occur only via hold.

Decomposition:
- Shared package game_pkg:
  - state encodings TITLE..FAIL;
  - key_find codes NONE/FIND_KEY/FIND_LIGHT/FIND_DOOR;
  - key origin constants and KEY_SIZE, reused by the sprite renderer.
- One natural sub-module, box_overlap: combinational AABB test, 9-bit inputs, 10-bit internal sums.

Test Plan:
- Reset then state=2, player (70,40), interact=1 for 30 frame_ticks -> key_pickup on tick 30, key_find=1, hold_progress=30 then 0 in COOLDOWN.
- Player (70,40), interact held 29 ticks then released -> no pickup, key_find=0, hold_progress=0.
- All three keys: (70,40), release, (240,40), release, (240,210) with 30-tick holds -> key_find 1, 2, 3; keys_done pulses once on the third.
- After a pickup, interact kept high 100 ticks at (240,40) -> no further pickup until release.
- key_find=2, state 2 -> 8 (FAIL) on the 30th tick -> no pickup. Then state 8 -> 2 -> key_find=0.
- rst_n=0 mid-HOLD at counter=15 -> all outputs 0, FSM IDLE next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-logic definitions: top-level state codes, key_find codes,
// key-tracker FSM states and the key box geometry used by the sprite renderer.
package game_pkg;

    // Top-level game state as driven by the main game FSM.
    typedef enum logic [3:0] {
        GS_TITLE    = 4'd0,
        GS_STORY    = 4'd1,
        GS_STAGE1   = 4'd2,
        GS_SUCCESS1 = 4'd3,
        GS_STAGE2   = 4'd4,
        GS_SUCCESS2 = 4'd5,
        GS_STAGE3   = 4'd6,
        GS_CLEAR    = 4'd7,
        GS_FAIL     = 4'd8
    } game_state_t;

    // key_find codes: which key/light sprite is active.
    typedef enum logic [1:0] {
        KF_NONE       = 2'd0,
        KF_FIND_KEY   = 2'd1,
        KF_FIND_LIGHT = 2'd2,
        KF_FIND_DOOR  = 2'd3
    } key_find_t;

    // Key tracker control states.
    typedef enum logic [2:0] {
        KT_IDLE     = 3'd0,
        KT_SEARCH   = 3'd1,
        KT_HOLD     = 3'd2,
        KT_COOLDOWN = 3'd3,
        KT_DONE     = 3'd4
    } kt_state_t;

    // Key box geometry in 320x240 space.
    localparam int KEY_SIZE = 20;
    localparam int KEY0_X   = 65;
    localparam int KEY0_Y   = 35;
    localparam int KEY1_X   = 235;
    localparam int KEY1_Y   = 35;
    localparam int KEY2_X   = 235;
    localparam int KEY2_Y   = 205;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test between the player hitbox
// (PLAYER_W square) and a key box (KEY_SIZE square). Sums are 10 bits wide
// so right/bottom edges never wrap.
module box_overlap #(
    parameter int PLAYER_W = 16,
    parameter int KEY_SIZE = 20
) (
    input  logic [8:0] px,
    input  logic [8:0] py,
    input  logic [8:0] kx,
    input  logic [8:0] ky,
    output logic       hit
);

    logic [9:0] p_right, p_bottom, k_right, k_bottom;
    logic       x_hit, y_hit;

    // Edges of both boxes and the per-axis interval overlap.
    always_comb begin
        p_right  = {1'b0, px} + 10'(PLAYER_W);
        p_bottom = {1'b0, py} + 10'(PLAYER_W);
        k_right  = {1'b0, kx} + 10'(KEY_SIZE);
        k_bottom = {1'b0, ky} + 10'(KEY_SIZE);
        x_hit    = ({1'b0, px} < k_right)  && (p_right  > {1'b0, kx});
        y_hit    = ({1'b0, py} < k_bottom) && (p_bottom > {1'b0, ky});
        hit      = x_hit && y_hit;
    end

endmodule

// File: rtl/key_tracker.sv
// Key-collection progress for STAGE1. Tracks which key is active, requires
// interact to be held for HOLD_FRAMES frames while overlapping the key, and
// pulses key_pickup / keys_done toward the top-level game FSM.
// Optional feature macro: KEY_SKIP_EN (adds skip_key; a rising edge forces
// an immediate pickup in SEARCH/HOLD/COOLDOWN).
//
// Handshake note: there is no valid/ready traffic here. key_pickup and
// keys_done are single-cycle registered pulses with no backpressure; the
// consumer must sample them on the cycle they are high.
module key_tracker
#(
    parameter int HOLD_FRAMES = 30,
    parameter int PLAYER_W    = 16,
    parameter int KEY_SIZE    = game_pkg::KEY_SIZE,
    parameter int KEY0_X      = game_pkg::KEY0_X,
    parameter int KEY0_Y      = game_pkg::KEY0_Y,
    parameter int KEY1_X      = game_pkg::KEY1_X,
    parameter int KEY1_Y      = game_pkg::KEY1_Y,
    parameter int KEY2_X      = game_pkg::KEY2_X,
    parameter int KEY2_Y      = game_pkg::KEY2_Y
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    input  logic       interact,
`ifdef KEY_SKIP_EN
    input  logic       skip_key,
`endif
    output logic [1:0] key_find,
    output logic       key_pickup,
    output logic       keys_done,
    output logic [4:0] hold_progress
);

    import game_pkg::*;

    kt_state_t  fsm, fsm_nxt;
    logic [1:0] key_find_nxt;
    logic [4:0] cnt, cnt_nxt, cnt_inc;
    logic       pickup_nxt, done_nxt, do_pickup;
    logic [3:0] prev_state;
    logic [8:0] kx, ky;
    logic       box_hit, overlap, engaged;
    logic       in_stage, entering, skip_edge;

    // Origin of the currently active key.
    always_comb begin
        kx = 9'(KEY0_X);
        ky = 9'(KEY0_Y);
        case (key_find)
            2'd1: begin kx = 9'(KEY1_X); ky = 9'(KEY1_Y); end
            2'd2: begin kx = 9'(KEY2_X); ky = 9'(KEY2_Y); end
            default: begin kx = 9'(KEY0_X); ky = 9'(KEY0_Y); end
        endcase
    end

    box_overlap #(
        .PLAYER_W (PLAYER_W),
        .KEY_SIZE (KEY_SIZE)
    ) u_box (
        .px  (player_x),
        .py  (player_y),
        .kx  (kx),
        .ky  (ky),
        .hit (box_hit)
    );

    // Once all keys are found nothing is left to overlap.
    assign overlap  = box_hit && (key_find != KF_FIND_DOOR);
    assign engaged  = overlap && interact;
    assign in_stage = (state == GS_STAGE1);
    assign entering = in_stage && (prev_state != GS_STAGE1);
    assign cnt_inc  = cnt + 5'd1;

`ifdef KEY_SKIP_EN
    logic skip_prev;
    assign skip_edge = skip_key && !skip_prev;

    // Previous skip_key level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) skip_prev <= 1'b0;
        else        skip_prev <= skip_key;
    end
`else
    assign skip_edge = 1'b0;
`endif

    // Next-state, counter and pulse logic; leaving STAGE1 overrides all else.
    always_comb begin
        fsm_nxt      = fsm;
        key_find_nxt = key_find;
        cnt_nxt      = cnt;
        pickup_nxt   = 1'b0;
        done_nxt     = 1'b0;
        do_pickup    = 1'b0;
        if (!in_stage) begin
            fsm_nxt = KT_IDLE;
            cnt_nxt = 5'd0;
        end else begin
            case (fsm)
                KT_IDLE: begin
                    if (entering) begin
                        key_find_nxt = KF_NONE;
                        cnt_nxt      = 5'd0;
                        fsm_nxt      = KT_SEARCH;
                    end
                end
                KT_SEARCH: begin
                    if (skip_edge) begin
                        do_pickup = 1'b1;
                    end else if (engaged) begin
                        fsm_nxt = KT_HOLD;
                        cnt_nxt = 5'd0;
                    end
                end
                KT_HOLD: begin
                    if (skip_edge) begin
                        do_pickup = 1'b1;
                    end else if (!engaged) begin
                        fsm_nxt = KT_SEARCH;
                        cnt_nxt = 5'd0;
                    end else if (frame_tick) begin
                        if (cnt_inc == 5'(HOLD_FRAMES)) do_pickup = 1'b1;
                        else                            cnt_nxt   = cnt_inc;
                    end
                end
                KT_COOLDOWN: begin
                    cnt_nxt = 5'd0;
                    if (skip_edge)     do_pickup = 1'b1;
                    else if (!interact) fsm_nxt  = KT_SEARCH;
                end
                KT_DONE: begin
                    cnt_nxt = 5'd0;
                end
                default: begin
                    fsm_nxt = KT_IDLE;
                    cnt_nxt = 5'd0;
                end
            endcase
        end
        // A pickup shows a full progress bar for the pulse cycle.
        if (do_pickup) begin
            key_find_nxt = key_find + 2'd1;
            pickup_nxt   = 1'b1;
            cnt_nxt      = 5'(HOLD_FRAMES);
            if (key_find_nxt == KF_FIND_DOOR) begin
                done_nxt = 1'b1;
                fsm_nxt  = KT_DONE;
            end else begin
                fsm_nxt  = KT_COOLDOWN;
            end
        end
    end

    // State, counter, key progress and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= KT_IDLE;
            cnt        <= 5'd0;
            key_find   <= KF_NONE;
            key_pickup <= 1'b0;
            keys_done  <= 1'b0;
            prev_state <= GS_TITLE;
        end else begin
            fsm        <= fsm_nxt;
            cnt        <= cnt_nxt;
            key_find   <= key_find_nxt;
            key_pickup <= pickup_nxt;
            keys_done  <= done_nxt;
            prev_state <= state;
        end
    end

    assign hold_progress = cnt;

endmodule
